// File: rtl/transmit_buffer_pkg.sv
// -----------------------------------------------------------------------------
// transmit_buffer_pkg
// Shared definitions for the byte-buffer family (transmit and receive sides).
//   txState_t  : IDLE / START / WAIT states of the transmit sequencer
//   BYTE_W     : width of one serial byte
//   byteOffset : bit offset of byte slot idx inside a maxBytes-wide word,
//                slot 0 being the most significant byte
// -----------------------------------------------------------------------------
package transmit_buffer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } txState_t;

    // Slot 0 is the top byte, so it sits at the highest offset.
    function automatic int byteOffset(input int maxBytes, input int idx);
        return (maxBytes - 1 - idx) * BYTE_W;
    endfunction

endpackage

// File: rtl/transmit_buffer_edge_pulse.sv
// -----------------------------------------------------------------------------
// edge_pulse
// Rising-edge detector. Registers the input every cycle and flags the cycle
// in which it goes from 0 to 1, so a level held high yields a single pulse.
// Ports:
//   clk   : system clock
//   rst   : asynchronous reset, active-high (clears the history bit)
//   level : input level or pulse to watch
//   pulse : high for the cycle in which level is 1 and was 0 the cycle before
// -----------------------------------------------------------------------------
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic levelPrev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            levelPrev <= 1'b0;
        end else begin
            levelPrev <= level;
        end
    end

    assign pulse = level & ~levelPrev;

endmodule

// File: rtl/transmit_buffer.sv
// -----------------------------------------------------------------------------
// transmit_buffer
// Captures a MAX_BYTES*8-bit word on request and feeds it, most significant
// byte first, to a byte-wide serial transmitter: one dataStart pulse per byte,
// then waits for the rising edge of txDone before moving to the next byte.
// Ports:
//   clk        : system clock
//   rst        : asynchronous reset, active-high; abandons any transfer
//   send       : request to transmit bufferIn, honoured only while ready=1
//   bufferIn   : word to send, captured on the accepted send
//   ready      : high while idle and able to accept send
//   dataOut    : byte presented to the transmitter, stable while waiting
//   dataStart  : one-cycle pulse, transmitter latches dataOut on it
//   txDone     : transmitter done (level or pulse), rising edge counts
//   done       : one-cycle pulse after the last byte's txDone edge
//   timeoutErr : one-cycle pulse when a byte waits TIMEOUT_CYCLES (if > 0)
// -----------------------------------------------------------------------------
module transmit_buffer
    import transmit_buffer_pkg::*;
#(
    parameter int MAX_BYTES      = 3,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        send,
    input  logic [MAX_BYTES*BYTE_W-1:0] bufferIn,
    output logic                        ready,
    output logic [BYTE_W-1:0]           dataOut,
    output logic                        dataStart,
    input  logic                        txDone,
    output logic                        done,
    output logic                        timeoutErr
);

    localparam int WORD_W = MAX_BYTES * BYTE_W;
    localparam int IDX_W  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MAX_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    txState_t          state;
    logic [IDX_W-1:0]  byteIdx;
    logic [WORD_W-1:0] shadow;
    logic [CNT_W-1:0]  timeoutCnt;
    logic              txEdge;

    function automatic logic [BYTE_W-1:0] sliceByte(input logic [WORD_W-1:0] word,
                                                    input int idx);
        return BYTE_W'(word >> byteOffset(MAX_BYTES, idx));
    endfunction

    edge_pulse uTxDoneEdge (
        .clk   (clk),
        .rst   (rst),
        .level (txDone),
        .pulse (txEdge)
    );

    assign ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            byteIdx    <= '0;
            shadow     <= '0;
            timeoutCnt <= '0;
            dataOut    <= '0;
            dataStart  <= 1'b0;
            done       <= 1'b0;
            timeoutErr <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for a single cycle.
            dataStart  <= 1'b0;
            done       <= 1'b0;
            timeoutErr <= 1'b0;

            case (state)
                IDLE: begin
                    if (send) begin
                        shadow    <= bufferIn;
                        byteIdx   <= '0;
                        dataOut   <= sliceByte(bufferIn, 0);
                        dataStart <= 1'b1;
                        state     <= START;
                    end
                end

                // dataStart is high during this state; any txDone edge seen
                // here belongs to the previous byte and is dropped.
                START: begin
                    timeoutCnt <= '0;
                    state      <= WAIT;
                end

                WAIT: begin
                    if (txEdge) begin
                        if (byteIdx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            byteIdx   <= byteIdx + 1'b1;
                            dataOut   <= sliceByte(shadow, int'(byteIdx) + 1);
                            dataStart <= 1'b1;
                            state     <= START;
                        end
                    end else if (TIMEOUT_CYCLES > 0) begin
                        // Fires on the TIMEOUT_CYCLES-th edge-free WAIT cycle.
                        if (timeoutCnt == CNT_LIMIT - 1'b1) begin
                            timeoutErr <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            timeoutCnt <= timeoutCnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/transmit_buffer.md
Name: transmit_buffer

Overview:
- Transmit-side counterpart of the receive byte buffer.
- Captures a MAX_BYTES*8-bit word on request and serializes it MSB byte first to the byte-wide serial transmitter: one start pulse per byte, then waits for the transmitter's done signal.
- Byte order matches the receive side: bits [23:16] go out first and land in byte slot 0 at the far end.
- Sits between the command/response logic and the serial transmitter.

Parameters:
- MAX_BYTES, 3, number of bytes per word; must be ≥1.
- TIMEOUT_CYCLES, 0, maximum cycles to wait for txDone per byte; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- send  in  1  request to transmit bufferIn; sampled only while ready=1.
- bufferIn  in  MAX_BYTES*8  word to send; captured on the accepted send.
- ready  out  1  high when IDLE and able to accept send.
- dataOut  out  8  current byte presented to the transmitter.
- dataStart  out  1  one-cycle pulse; the transmitter must latch dataOut on it.
- txDone  in  1  transmitter done, level or pulse; only its rising edge counts.
- done  out  1  one-cycle pulse after the last byte's txDone edge.
- timeoutErr  out  1  one-cycle pulse when a byte times out.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, byteIdx=0, shadow word=0.
  - dataOut=0, dataStart=0, done=0, timeoutErr=0.
  - ready=1 (ready is decoded from state==IDLE).
  - txDone edge-history register=0, timeout counter=0.
  - Reset mid-transfer abandons the word; no done pulse is issued.
- Edge detect: txEdge = txDone & ~txDonePrev, where txDonePrev is registered every cycle. A txDone held high yields exactly one edge.
- States:
  - IDLE:
    - On send=1, capture bufferIn into the shadow register, set byteIdx=0, load dataOut=bufferIn[top byte], go to START.
    - send=0: stay in IDLE.
  - START:
    - dataStart=1 for exactly this cycle.
    - Clear the timeout counter and go to WAIT unconditionally.
    - A txEdge seen in START is ignored.
  - WAIT:
    - On txEdge with byteIdx==MAX_BYTES-1: go to IDLE and pulse done on the next cycle.
    - On txEdge otherwise: byteIdx+1, load dataOut with the next lower byte, go to START.
    - With no edge and TIMEOUT_CYCLES>0: increment the counter; when it reaches TIMEOUT_CYCLES, go to IDLE and pulse timeoutErr, with no done pulse.
- Latency:
  - send accepted at cycle N gives dataStart at N+1.
  - txEdge at cycle M gives the next dataStart (or done) at M+1.
- Registered outputs:
  - dataOut changes only when a byte is loaded and holds stable through WAIT.
  - dataOut keeps the last byte after completion.
- Busy and back-to-back:
  - send while ready=0 is ignored, not queued; bufferIn changes after capture have no effect.
  - ready rises in the same cycle done pulses, so a new send is accepted that cycle at the earliest.
- txEdge in IDLE is ignored.
- Counter widths: byteIdx clog2(MAX_BYTES) bits, minimum 1; timeout counter clog2(TIMEOUT_CYCLES+1) bits.

Decomposition:
- Shared package holds:
  - state enum IDLE/START/WAIT;
  - BYTE_W=8;
  - helper function for the byte slice offset, (MAX_BYTES-1-idx)*8, shared with the receive buffer.
- One sub-module: edge_pulse (rising-edge detector with async active-high reset), reusable by other blocks.

Test Plan:
- Reset, then send=1 with bufferIn=0xA1B2C3, transmitter model replying txDone 4 cycles after each dataStart:
  - dataStart pulses carry 0xA1, 0xB2, 0xC3 in that order;
  - done pulses once, 1 cycle after the third txDone rise;
  - ready returns to 1.
- Send again during transfer with bufferIn=0xFFFFFF: ignored; the original bytes are unchanged and exactly 3 dataStart pulses occur.
- txDone held high for 10 cycles after each byte: exactly one byte advance per rise; no skipped bytes.
- TIMEOUT_CYCLES=8, transmitter never answers byte 1:
  - timeoutErr pulses 8 cycles after entering WAIT;
  - done stays 0, ready=1, and a subsequent send restarts at byte 0.
- Assert rst while in WAIT on byte 2:
  - all outputs return to reset values asynchronously;
  - no done pulse;
  - the next send=1 with 0x010203 emits 0x01 first.
- Send asserted in the same cycle done pulses, with bufferIn=0x445566: accepted; dataStart with 0x44 follows on the next cycle.
